// File: rtl/eq_pkg.sv
// Shared equalizer constants and the scheduler state type, used by the queues, FIR and scheduler.
package eq_pkg;

    localparam int EQ_TAPS   = 1021;
    localparam int EQ_ADDR_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_SEQ,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/eq_tap_counter.sv
// Coefficient address counter plus the accumulator clear/enable alignment for one convolution window.
module eq_tap_counter
    import eq_pkg::*;
#(
    parameter int TAPS   = EQ_TAPS,
    parameter int ADDR_W = EQ_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              start,
    input  logic              adv,
    output logic [ADDR_W-1:0] coeff_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              ovf
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);

    logic [ADDR_W-1:0] addr_p0;
    logic              at_end_p0;
    logic              en_p1;

    // p0: address presented to ROM/queue; p1: data returns, accumulate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_p0   <= '0;
            at_end_p0 <= 1'b0;
            en_p1     <= 1'b0;
        end else begin
            en_p1 <= adv;
            if (clr) begin
                addr_p0   <= '0;
                at_end_p0 <= 1'b0;
            end else if (adv) begin
                if (addr_p0 == LAST) at_end_p0 <= 1'b1;
                else                 addr_p0   <= addr_p0 + 1'b1;
            end
        end
    end

    // Once the last coefficient has been used the address parks; any further read is an overrun.
    assign ovf        = adv & at_end_p0;
    assign coeff_addr = addr_p0;
    assign acc_clr    = start;
    assign acc_en     = en_p1;

endmodule

// File: rtl/eq_band_sched.sv
// Per-sample scheduler for the high/low band queues and shared FIR tap sequencing.
// Define EQ_SCHED_PEND_EN to buffer one sample arriving while a frame is still busy.
module eq_band_sched
    import eq_pkg::*;
#(
    parameter int TAPS   = EQ_TAPS,
    parameter int ADDR_W = EQ_ADDR_W,
    parameter int DECIM  = 2,
    parameter int SEQ_TO = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld,
    input  logic              low_seq,
    input  logic              high_seq,
    output logic              wrt_low,
    output logic              wrt_high,
    output logic [ADDR_W-1:0] coeff_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              low_done,
    output logic              high_done,
    output logic              busy,
    output logic              err
);

    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int TW = $clog2(SEQ_TO + 1);
    localparam logic [DW-1:0] DLAST = DW'(DECIM - 1);
    localparam logic [TW-1:0] TLAST = TW'(SEQ_TO - 1);

    sched_state_t  state, nxt;
    logic [DW-1:0] dcnt;
    logic [TW-1:0] tcnt;
    logic          low_wr, low_seen;
    logic          clr, start, adv, chk;
    logic          go_write, drop, mism, ovf;

`ifdef EQ_SCHED_PEND_EN
    logic pend;
    logic exit_frame;

    assign exit_frame = (state == DONE) || (state == WAIT_SEQ && !high_seq && tcnt == TLAST);
    assign go_write   = pend | vld;
    assign drop       = busy & vld & pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     pend <= 1'b0;
        else if (exit_frame)            pend <= 1'b0;
        else if (busy && vld && !pend)  pend <= 1'b1;
    end
`else
    assign go_write = 1'b0;
    assign drop     = busy & vld;
`endif

    assign mism = chk & low_wr & (low_seq ^ high_seq);

    always_comb begin
        nxt       = state;
        wrt_high  = 1'b0;
        wrt_low   = 1'b0;
        clr       = 1'b0;
        start     = 1'b0;
        adv       = 1'b0;
        chk       = 1'b0;
        low_done  = 1'b0;
        high_done = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: if (vld) nxt = WRITE;
            WRITE: begin
                wrt_high = 1'b1;
                wrt_low  = (dcnt == DLAST);
                clr      = 1'b1;
                nxt      = WAIT_SEQ;
            end
            WAIT_SEQ: begin
                if (high_seq) begin
                    start = 1'b1;
                    adv   = 1'b1;
                    chk   = 1'b1;
                    nxt   = RUN;
                end else if (tcnt == TLAST) begin
                    nxt = go_write ? WRITE : IDLE;
                end
            end
            // The cycle that sees high_seq low is the drain cycle: its delayed acc_en is the last one.
            RUN: begin
                chk = 1'b1;
                if (high_seq) adv = 1'b1;
                else          nxt = DONE;
            end
            DRAIN: nxt = DONE;
            DONE: begin
                high_done = 1'b1;
                low_done  = low_wr & low_seen;
                nxt       = go_write ? WRITE : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dcnt     <= '0;
            tcnt     <= '0;
            low_wr   <= 1'b0;
            low_seen <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= nxt;
            err   <= err | drop | mism | ovf;
            if (state == WRITE) begin
                dcnt     <= (dcnt == DLAST) ? '0 : dcnt + 1'b1;
                low_wr   <= wrt_low;
                low_seen <= 1'b0;
                tcnt     <= '0;
            end else begin
                if (state == WAIT_SEQ) tcnt <= tcnt + 1'b1;
                if (chk && low_seq)    low_seen <= 1'b1;
            end
        end
    end

    eq_tap_counter #(
        .TAPS   (TAPS),
        .ADDR_W (ADDR_W)
    ) u_tap (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .start      (start),
        .adv        (adv),
        .coeff_addr (coeff_addr),
        .acc_clr    (acc_clr),
        .acc_en     (acc_en),
        .ovf        (ovf)
    );

endmodule

// File: tb/tb_eq_band_sched.sv
// Bench for eq_band_sched: plans whole frames from the scheduling rules into per-cycle tables, then replays them.
module tb_eq_band_sched;

    localparam int TAPS   = 1021;
    localparam int ADDR_W = 10;
    localparam int DECIM  = 2;
    localparam int SEQ_TO = 3;
    localparam int HFILL  = 4;
    localparam int LFILL  = 2;
    localparam int NC     = 40000;
`ifdef EQ_SCHED_PEND_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif

    logic clk = 1'b1;
    logic rst_n = 1'b0, vld = 1'b0, low_seq = 1'b0, high_seq = 1'b0;
    logic wrt_low, wrt_high, acc_clr, acc_en, low_done, high_done, busy, err;
    logic [ADDR_W-1:0] coeff_addr;

    eq_band_sched #(.TAPS(TAPS), .ADDR_W(ADDR_W), .DECIM(DECIM), .SEQ_TO(SEQ_TO)) dut (
        .clk(clk), .rst_n(rst_n), .vld(vld), .low_seq(low_seq), .high_seq(high_seq),
        .wrt_low(wrt_low), .wrt_high(wrt_high), .coeff_addr(coeff_addr), .acc_clr(acc_clr),
        .acc_en(acc_en), .low_done(low_done), .high_done(high_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    bit vld_a [NC], hs_a [NC], ls_a [NC], rstn_a [NC], err_evt [NC];
    bit e_wh [NC], e_wl [NC], e_clr [NC], e_en [NC], e_ld [NC], e_hd [NC], e_busy [NC], e_err [NC];
    int e_addr [NC];

    int  cur, k, hw, lw, total;
    bit  chain;
    int  ws, w_t, w_r1, w_r2, wd;
    int  n_vec = 0, n_miss = 0;

    // One frame: write at w, queue read window, accumulate window, done, and any samples arriving while busy.
    task automatic do_frame(input int L, input bit le, input int x1, input int x2,
                            input int cut_off, output int w);
        int e, c, Le, nb, rc;
        int xs [2];
        bit lowwr, lowon, seen, found;
        if (chain) w = cur;
        else begin
            w = cur + int'($urandom_range(1, 4));
            vld_a[w-1] = 1'b1;
        end
        lowwr = (k % DECIM) == DECIM - 1;
        k++; hw++;
        if (lowwr) lw++;
        Le    = (hw >= HFILL) ? L : 0;
        lowon = lowwr && (lw >= LFILL);
        e_wh[w] = 1'b1;
        e_wl[w] = lowwr;
        seen = 1'b0;
        for (int i = 1; i <= Le; i++) begin
            c = w + i;
            hs_a[c]   = 1'b1;
            e_addr[c] = (i - 1 < TAPS - 1) ? i - 1 : TAPS - 1;
            if (lowon && !(le && i == Le)) begin
                ls_a[c] = 1'b1;
                seen = 1'b1;
            end
        end
        if (Le > 0) begin
            e = w + Le + 2;
            e_clr[w+1] = 1'b1;
            for (int i = 2; i <= Le + 1; i++) e_en[w+i] = 1'b1;
            e_hd[e] = 1'b1;
            e_ld[e] = lowwr && seen;
            if (Le > TAPS) err_evt[w+TAPS+2] = 1'b1;
            if (lowwr) begin
                found = 1'b0;
                for (c = w + 1; c <= w + Le + 1; c++)
                    if (!found && hs_a[c] != ls_a[c]) begin
                        err_evt[c+1] = 1'b1;
                        found = 1'b1;
                    end
            end
        end else begin
            e = w + SEQ_TO;
        end
        for (c = w; c <= e; c++) e_busy[c] = 1'b1;
        xs[0] = x1; xs[1] = x2;
        nb = 0; chain = 1'b0;
        foreach (xs[j]) begin
            if (xs[j] >= 0 && w + xs[j] <= e) begin
                c = w + xs[j];
                vld_a[c] = 1'b1;
                if (PEND && nb == 0) chain = 1'b1;
                else                 err_evt[c+1] = 1'b1;
                nb++;
            end
        end
        cur = e + 1;
        if (cut_off >= 0) begin
            rc = w + cut_off;
            for (c = rc; c <= e + 2; c++) begin
                vld_a[c] = 0; hs_a[c] = 0; ls_a[c] = 0; err_evt[c] = 0;
                e_wh[c] = 0; e_wl[c] = 0; e_clr[c] = 0; e_en[c] = 0;
                e_ld[c] = 0; e_hd[c] = 0; e_busy[c] = 0; e_addr[c] = -1;
            end
            for (c = rc; c < rc + 3; c++) begin
                rstn_a[c] = 1'b0;
                e_addr[c] = 0;
            end
            k = 0; chain = 1'b0; cur = rc + 3;
        end
    endtask

    task automatic chk(input string nm, input int c, input logic [15:0] act, input int exp);
        n_vec++;
        if (act !== 16'(exp)) begin
            n_miss++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, act, exp);
        end
    endtask

    initial begin
        int r, x1, x2;
        bit er;
        for (int c = 0; c < NC; c++) begin
            rstn_a[c] = 1'b1;
            e_addr[c] = -1;
        end
        for (int c = 0; c < 3; c++) begin
            rstn_a[c] = 1'b0;
            e_addr[c] = 0;
        end
        cur = 3; k = 0; hw = 0; lw = 0; chain = 1'b0;

        // queue filling: first frames time out, then steady frames
        do_frame(TAPS, 0, -1, -1, -1, w_t);
        do_frame(TAPS, 0, -1, -1, -1, wd);
        do_frame(TAPS, 0, -1, -1, -1, wd);
        do_frame(TAPS, 0, -1, -1, -1, wd);
        do_frame(TAPS, 0, -1, -1, -1, wd);
        do_frame(TAPS, 0, -1, -1, -1, ws);
        // samples arriving while busy, then a forced timeout with full queue
        do_frame(TAPS, 0, int'($urandom_range(3, 1000)), -1, -1, wd);
        do_frame(TAPS, 0, -1, -1, -1, wd);
        x1 = int'($urandom_range(0, TAPS));
        do_frame(TAPS, 0, x1, x1 + 2, -1, wd);
        do_frame(TAPS, 0, -1, -1, -1, wd);
        do_frame(0, 0, -1, -1, -1, wd);
        // reset mid-run, decimation restarts
        do_frame(TAPS, 0, -1, -1, 500, wd);
        do_frame(TAPS, 0, -1, -1, -1, w_r1);
        do_frame(TAPS, 0, -1, -1, -1, w_r2);
        // low band drops sequencing one cycle early
        if (k % DECIM != DECIM - 1) do_frame(TAPS, 0, -1, -1, -1, wd);
        do_frame(TAPS, 1, -1, -1, -1, wd);
        do_frame(TAPS, 0, -1, -1, -1, wd);
        do_frame(TAPS, 0, -1, -1, 200, wd);
        // high_seq overruns the coefficient count
        do_frame(TAPS + 2, 0, -1, -1, -1, wd);
        do_frame(TAPS, 0, -1, -1, -1, wd);
        do_frame(TAPS, 0, -1, -1, 30, wd);
        for (int f = 0; f < 8 && cur < NC - 4000; f++) begin
            r  = int'($urandom_range(0, 9));
            x1 = (r >= 6) ? int'($urandom_range(0, TAPS + 2)) : -1;
            x2 = (r >= 8) ? x1 + int'($urandom_range(1, 40)) : -1;
            do_frame((r == 0) ? 0 : TAPS, 0, x1, x2, -1, wd);
        end
        do_frame(TAPS, 0, -1, -1, -1, wd);
        total = cur + 5;

        er = 1'b0;
        for (int c = 0; c < NC; c++) begin
            if (!rstn_a[c])     er = 1'b0;
            else if (err_evt[c]) er = 1'b1;
            e_err[c] = er;
        end

        for (int c = 0; c < total; c++) begin
            if (c > 0) @(posedge clk);
            #1;
            rst_n    = rstn_a[c];
            vld      = vld_a[c];
            high_seq = hs_a[c];
            low_seq  = ls_a[c];
            @(negedge clk);
            chk("wrt_high",  c, wrt_high,  e_wh[c]);
            chk("wrt_low",   c, wrt_low,   e_wl[c]);
            chk("acc_clr",   c, acc_clr,   e_clr[c]);
            chk("acc_en",    c, acc_en,    e_en[c]);
            chk("low_done",  c, low_done,  e_ld[c]);
            chk("high_done", c, high_done, e_hd[c]);
            chk("busy",      c, busy,      e_busy[c]);
            chk("err",       c, err,       e_err[c]);
            if (e_addr[c] >= 0) chk("coeff_addr", c, coeff_addr, e_addr[c]);
            if (c == ws)        chk("pin_wrt_high", c, wrt_high, 1);
            if (c == ws + 1)    chk("pin_acc_clr", c, acc_clr, 1);
            if (c == ws + 1)    chk("pin_addr0", c, coeff_addr, 0);
            if (c == ws + 2)    chk("pin_first_en", c, acc_en, 1);
            if (c == ws + 1021) chk("pin_addr_last", c, coeff_addr, 1020);
            if (c == ws + 1022) chk("pin_last_en", c, acc_en, 1);
            if (c == ws + 1023) chk("pin_high_done", c, high_done, 1);
            if (c == ws + 1024) chk("pin_en_off", c, acc_en, 0);
            if (c == ws + 1024) chk("pin_idle", c, busy, 0);
            if (c == w_t + 3)   chk("pin_to_busy", c, busy, 1);
            if (c == w_t + 4)   chk("pin_to_idle", c, busy, 0);
            if (c == w_r1)      chk("pin_rst_nolow", c, wrt_low, 0);
            if (c == w_r2)      chk("pin_rst_low", c, wrt_low, 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
